// File: rtl/gb_pkg.sv
// Shared Game Boy bus constants, the OAM DMA state encoding and the
// echo-RAM source page remap used by the DMA engine.
package gb_pkg;

  localparam logic [15:0] OAM_BASE   = 16'hFE00;
  localparam logic [15:0] DMA_REG    = 16'hFF46;
  localparam int          OAM_LENGTH = 160;
  localparam logic [7:0]  ECHO_PAGE  = 8'hE0;

  typedef enum logic [1:0] {
    IDLE,
    START,
    COPY
  } dma_state_e;

  // Pages E0-FF mirror work RAM at C0-DF.
  function automatic logic [7:0] source_page(input logic [7:0] src_hi);
    return (src_hi >= ECHO_PAGE) ? (src_hi - 8'h20) : src_hi;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine behind register 0xFF46: copies LENGTH bytes from page
// src_hi into sprite attribute memory through the shared bus master port.
module oam_dma
  import gb_pkg::*;
#(
  parameter int LENGTH       = OAM_LENGTH,
  parameter int BYTE_CYCLES  = 4,
  parameter int START_CYCLES = 4
) (
  input  logic        clockgb,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  indata,
  output logic [7:0]  outdata,
  input  logic        load,
  input  logic        store,
  output logic [15:0] dma_address,
  output logic [7:0]  dma_outdata,
  input  logic [7:0]  dma_indata,
  output logic        dma_load,
  output logic        dma_store,
  output logic        active
);

  localparam logic [7:0] START_LAST = 8'(START_CYCLES - 1);
  localparam logic [7:0] PHASE_LAST = 8'(BYTE_CYCLES - 1);
  localparam logic [7:0] IDX_LAST   = 8'(LENGTH - 1);

  dma_state_e state_q, state_d;
  logic [7:0] src_q, src_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] phase_q, phase_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic [7:0] outdata_q;
  logic       reg_write;
  logic       reg_read;

  assign reg_write = store && (address == DMA_REG);
  assign reg_read  = load && (address == DMA_REG);

  always_ff @(posedge clockgb) begin
    if (reset) begin
      state_q   <= IDLE;
      src_q     <= 8'h00;
      idx_q     <= 8'h00;
      phase_q   <= 8'h00;
      cnt_q     <= 8'h00;
      data_q    <= 8'h00;
      outdata_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      idx_q     <= idx_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      // src_q is sampled before its update, so a same-cycle store reads back the old value.
      outdata_q <= reg_read ? src_q : 8'h00;
    end
  end

  // Master port: dma_load and dma_store are single-cycle strobes that are
  // never high together; read data is expected on dma_indata the cycle after
  // dma_load, and a dma_store writes dma_outdata to dma_address that cycle.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    idx_d       = idx_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    dma_address = 16'h0000;
    dma_outdata = 8'h00;
    dma_load    = 1'b0;
    dma_store   = 1'b0;

    case (state_q)
      START: begin
        if (cnt_q == START_LAST) begin
          state_d = COPY;
          cnt_d   = 8'h00;
          idx_d   = 8'h00;
          phase_d = 8'h00;
        end else begin
          cnt_d = cnt_q + 8'h01;
        end
      end
      COPY: begin
        if (phase_q == 8'd0) begin
          dma_load    = 1'b1;
          dma_address = {source_page(src_q), idx_q};
        end else if (phase_q == 8'd1) begin
          data_d = dma_indata;
        end else if (phase_q == 8'd2) begin
          dma_store   = 1'b1;
          dma_address = OAM_BASE + {8'h00, idx_q};
          dma_outdata = data_q;
        end

        if (phase_q == PHASE_LAST) begin
          phase_d = 8'h00;
          if (idx_q == IDX_LAST) begin
            state_d = IDLE;
            idx_d   = 8'h00;
          end else begin
            idx_d = idx_q + 8'h01;
          end
        end else begin
          phase_d = phase_q + 8'h01;
        end
      end
      default: ;
    endcase

    // A register write wins over everything; strobes above still fire this cycle.
    if (reg_write) begin
      src_d   = indata;
      state_d = START;
      cnt_d   = 8'h00;
      idx_d   = 8'h00;
      phase_d = 8'h00;
    end
  end

  assign active  = (state_q != IDLE);
  assign outdata = outdata_q;

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboarded bench for oam_dma: default-size instance checked through
// expected queues, plus a short LENGTH=8 / BYTE_CYCLES=6 instance.
module tb_oam_dma;

  logic        clockgb;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  indata;
  logic        load;
  logic        store;
  logic        store_b;
  logic        load_b;

  logic [7:0]  outdata, outdata_b;
  logic [15:0] dma_address, dma_address_b;
  logic [7:0]  dma_outdata, dma_outdata_b;
  logic [7:0]  dma_indata, dma_indata_b;
  logic        dma_load, dma_load_b;
  logic        dma_store, dma_store_b;
  logic        active, active_b;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_load_q[$];
  logic [23:0] exp_store_q[$];
  logic [31:0] exp_span_q[$];
  logic [7:0]  exp_rd_q[$];

  logic rd_pend = 1'b0;
  int   a_cnt = 0;

  // ---------------- clock / reset ----------------
  initial clockgb = 1'b0;
  always #5 clockgb = ~clockgb;

  oam_dma u_dut (
    .clockgb     (clockgb),
    .reset       (reset),
    .address     (address),
    .indata      (indata),
    .outdata     (outdata),
    .load        (load),
    .store       (store),
    .dma_address (dma_address),
    .dma_outdata (dma_outdata),
    .dma_indata  (dma_indata),
    .dma_load    (dma_load),
    .dma_store   (dma_store),
    .active      (active)
  );

  oam_dma #(.LENGTH(8), .BYTE_CYCLES(6), .START_CYCLES(4)) u_dut_b (
    .clockgb     (clockgb),
    .reset       (reset),
    .address     (address),
    .indata      (indata),
    .outdata     (outdata_b),
    .load        (load_b),
    .store       (store_b),
    .dma_address (dma_address_b),
    .dma_outdata (dma_outdata_b),
    .dma_indata  (dma_indata_b),
    .dma_load    (dma_load_b),
    .dma_store   (dma_store_b),
    .active      (active_b)
  );

  // Source memory: (addr & 0xFF) ^ 0x5A, one cycle after the read strobe.
  always @(posedge clockgb) begin
    if (dma_load)   dma_indata   <= dma_address[7:0] ^ 8'h5A;
    if (dma_load_b) dma_indata_b <= dma_address_b[7:0] ^ 8'h5A;
    rd_pend <= load;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    address = a; indata = d; store = 1'b1;
    @(negedge clockgb);
    store = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp);
    exp_rd_q.push_back(exp);
    address = a; load = 1'b1;
    @(negedge clockgb);
    load = 1'b0;
  endtask

  task automatic cpu_wr_rd(input logic [7:0] d, input logic [7:0] exp_old);
    exp_rd_q.push_back(exp_old);
    address = 16'hFF46; indata = d; store = 1'b1; load = 1'b1;
    @(negedge clockgb);
    store = 1'b0; load = 1'b0;
  endtask

  task automatic push_xfer(input logic [7:0] page, input int n_loads, input int n_stores);
    for (int i = 0; i < n_loads; i++) exp_load_q.push_back({page, 8'(i)});
    for (int i = 0; i < n_stores; i++)
      exp_store_q.push_back({16'hFE00 + 16'(i), 8'(i) ^ 8'h5A});
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (active && n < limit) begin
      @(negedge clockgb);
      n++;
    end
    check("idle_within_budget", 32'(n < limit), 32'd1);
    repeat (3) @(negedge clockgb);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clockgb) begin
    if (dma_load || dma_store)
      check("strobe_exclusive", 32'(dma_load && dma_store), 32'd0);
    if (dma_load) begin
      if (exp_load_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_load: got addr %0h expected no load", dma_address);
      end else begin
        check("load_addr", 32'(dma_address), 32'(exp_load_q.pop_front()));
      end
    end
    if (dma_store) begin
      check("store_in_oam", 32'(dma_address >= 16'hFE00 && dma_address <= 16'hFE9F), 32'd1);
      if (exp_store_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_store: got %0h expected no store", {dma_address, dma_outdata});
      end else begin
        check("store_addr_data", 32'({dma_address, dma_outdata}), 32'(exp_store_q.pop_front()));
      end
    end
    if (rd_pend) begin
      if (exp_rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_read: got %0h expected no read", outdata);
      end else begin
        check("reg_read", 32'(outdata), 32'(exp_rd_q.pop_front()));
      end
    end
    if (active) begin
      a_cnt++;
    end else if (a_cnt != 0) begin
      if (exp_span_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_span: got %0d expected none", a_cnt);
      end else begin
        check("active_span", 32'(a_cnt), exp_span_q.pop_front());
      end
      a_cnt = 0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k, ph;
    logic in_copy, exp_ld, exp_st;

    reset = 1'b1; address = 16'h0000; indata = 8'h00;
    load = 1'b0; store = 1'b0; store_b = 1'b0; load_b = 1'b0;
    repeat (3) @(negedge clockgb);
    check("rst_active", 32'(active), 32'd0);
    check("rst_outputs", 32'({dma_load, dma_store, dma_address, dma_outdata}), 32'd0);
    check("rst_outdata", 32'(outdata), 32'd0);
    reset = 1'b0;
    @(negedge clockgb);
    cpu_read(16'hFF46, 8'h00);

    // Full transfer from page C0.
    push_xfer(8'hC0, 160, 160);
    exp_span_q.push_back(32'd644);
    cpu_write(16'hFF46, 8'hC0);
    check("active_rise", 32'(active), 32'd1);
    repeat (3) @(negedge clockgb);
    check("no_load_cycle4", 32'(dma_load), 32'd0);
    @(negedge clockgb);
    check("first_load_cycle5", 32'({dma_load, dma_address}), 32'h1C000);
    cpu_read(16'hFF45, 8'h00);
    cpu_read(16'hFF47, 8'h00);
    cpu_read(16'hFF46, 8'hC0);
    wait_idle(1000);

    // Echo page E1 reads from C1.
    push_xfer(8'hC1, 160, 160);
    exp_span_q.push_back(32'd644);
    cpu_write(16'hFF46, 8'hE1);
    cpu_read(16'hFF46, 8'hE1);
    wait_idle(1000);

    // Restart on the phase-2 store of byte 49: that store completes, then D0 from byte 0.
    push_xfer(8'hC0, 50, 50);
    push_xfer(8'hD0, 160, 160);
    exp_span_q.push_back(32'd847);
    cpu_write(16'hFF46, 8'hC0);
    repeat (202) @(negedge clockgb);
    cpu_write(16'hFF46, 8'hD0);
    wait_idle(1200);

    // Reset during byte 80 (phase 1): load of byte 80 seen, its store never is.
    push_xfer(8'hC0, 81, 80);
    exp_span_q.push_back(32'd326);
    cpu_write(16'hFF46, 8'hC0);
    repeat (325) @(negedge clockgb);
    reset = 1'b1;
    @(negedge clockgb);
    reset = 1'b0;
    check("abort_active", 32'(active), 32'd0);
    check("abort_strobes", 32'({dma_load, dma_store, dma_address, dma_outdata}), 32'd0);
    cpu_read(16'hFF46, 8'h00);

    // Store and load of the register together return the old value.
    push_xfer(8'h33, 160, 160);
    exp_span_q.push_back(32'd644);
    cpu_wr_rd(8'h33, 8'h00);
    cpu_read(16'hFF46, 8'h33);
    wait_idle(1000);

    // Short instance: 8 bytes, 6 cycles each, active for 4 + 48 cycles.
    address = 16'hFF46; indata = 8'hC2; store_b = 1'b1;
    @(negedge clockgb);
    store_b = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      in_copy = (n >= 5) && (n <= 52);
      k  = (n - 5) / 6;
      ph = (n - 5) % 6;
      exp_ld = in_copy && (ph == 0);
      exp_st = in_copy && (ph == 2);
      check("b_active", 32'(active_b), 32'(n <= 52));
      check("b_load", 32'(dma_load_b), 32'(exp_ld));
      check("b_store", 32'(dma_store_b), 32'(exp_st));
      if (exp_ld) check("b_load_addr", 32'(dma_address_b), 32'({8'hC2, 8'(k)}));
      if (exp_st) begin
        check("b_store_addr", 32'(dma_address_b), 32'(16'hFE00 + 16'(k)));
        check("b_store_data", 32'(dma_outdata_b), 32'(8'(k) ^ 8'h5A));
      end
      @(negedge clockgb);
    end

    // ---------------- final report ----------------
    check("load_q_drained", exp_load_q.size(), 32'd0);
    check("store_q_drained", exp_store_q.size(), 32'd0);
    check("span_q_drained", exp_span_q.size(), 32'd0);
    check("read_q_drained", exp_rd_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
